pipeline_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage core. Takes the combinational load/branch hazard

---
 rtl/pipeline_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage core.
// Combines the decode hazard, EX redirect, multi-cycle mul/div status and the
// data-memory handshake into per-stage stall/flush enables. A small FSM covers
// multi-cycle events, and two saturating counters track stall cycles and redirects.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // IF/ID + ID/EX flush cycles per redirect (1..3)
    parameter int MD_TIMEOUT   = 64,  // MD_WAIT cycle limit before forced exit (>= 2)
    parameter int CNT_W        = 32   // performance counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    input  logic             muldiv_done,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             exmem_flush,
    output logic             memwb_stall,
    output logic [2:0]       ctrl_state,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_MD_WAIT  = 3'd3
    } state_t;

    localparam int TMR_W = $clog2(MD_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [1:0]       fl_cnt_q, fl_cnt_d;
    logic [TMR_W-1:0] md_tmr_q, md_tmr_d;
    logic             md_timeout_q, md_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic eff_run;
    logic tmo;
    logic p1_mem;
    logic p2_redir;
    logic p3_md;
    logic p4_hz;
    logic redir_accept;

    // Decode the priority conditions from registered state and live inputs.
    // The ack cycle of MEM_WAIT behaves like RUN: the pipeline advances that
    // cycle, so a branch held in EX must redirect then and hazards must bubble.
    always_comb begin
        eff_run      = (state_q == ST_RUN) || ((state_q == ST_MEM_WAIT) && dmem_ack);
        tmo          = (state_q == ST_MD_WAIT) && (md_tmr_q == TMR_W'(MD_TIMEOUT - 1));
        p1_mem       = (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && dmem_req && !dmem_ack)
                       || ((state_q == ST_MEM_WAIT) && !dmem_ack);
        p2_redir     = (eff_run && branch_taken) || (state_q == ST_FLUSH);
        p3_md        = (eff_run && muldiv_start && !muldiv_done)
                       || ((state_q == ST_MD_WAIT) && !muldiv_done && !tmo);
        p4_hz        = eff_run && hz;
        redir_accept = eff_run && branch_taken && !p1_mem;
    end

    // Stage enables in priority order; reset forces NOPs into the front stages.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        memwb_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (p1_mem) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_stall = 1'b1;
        end else if (p2_redir) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (p3_md) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
        end else if (p4_hz) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    // Next-state logic for the FSM, flush counter, mul/div timer and sticky timeout.
    always_comb begin
        state_d      = state_q;
        fl_cnt_d     = fl_cnt_q;
        md_tmr_d     = md_tmr_q;
        md_timeout_d = md_timeout_q;
        if (p1_mem) begin
            // FLUSH and MEM_WAIT hold everything while memory is busy.
            if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
            end
        end else if (eff_run) begin
            state_d = ST_RUN;
            if (branch_taken) begin
                if (FLUSH_CYCLES > 1) begin
                    state_d  = ST_FLUSH;
                    fl_cnt_d = 2'(FLUSH_CYCLES - 1);
                end
            end else if (muldiv_start && !muldiv_done) begin
                state_d  = ST_MD_WAIT;
                md_tmr_d = TMR_W'(1);
            end
        end else if (state_q == ST_FLUSH) begin
            fl_cnt_d = fl_cnt_q - 2'd1;
            if (fl_cnt_q == 2'd1) begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_MD_WAIT) begin
            md_tmr_d = md_tmr_q + TMR_W'(1);
            if (muldiv_done) begin
                state_d = ST_RUN;
            end else if (tmo) begin
                state_d      = ST_RUN;
                md_timeout_d = 1'b1;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // Saturating performance counters; a clear beats a same-cycle increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (redir_accept && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= ST_RUN;
            fl_cnt_q     <= '0;
            md_tmr_q     <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fl_cnt_q     <= fl_cnt_d;
            md_tmr_q     <= md_tmr_d;
            md_timeout_q <= md_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ctrl_state = state_q;
    assign md_timeout = md_timeout_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: a default-parameter instance driven through a
// cycle-by-cycle vector table, and a FLUSH_CYCLES=2 / MD_TIMEOUT=4 / CNT_W=4
// instance exercised by hand-written multi-cycle sequences. Both share inputs.
module tb_pipeline_ctrl;

    // Input bundle order: {hz, branch_taken, muldiv_start, muldiv_done, dmem_req, dmem_ack, cnt_clr}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_HZ   = 7'b1000000;
    localparam logic [6:0] I_BR   = 7'b0100000;
    localparam logic [6:0] I_MS   = 7'b0010000;
    localparam logic [6:0] I_MD   = 7'b0001000;
    localparam logic [6:0] I_REQ  = 7'b0000100;
    localparam logic [6:0] I_ACK  = 7'b0000010;
    localparam logic [6:0] I_CLR  = 7'b0000001;

    // Enable bundle order: {pc_s, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, exmem_f}
    localparam logic [7:0] E_NONE  = 8'b00000_000;
    localparam logic [7:0] E_MEM   = 8'b11111_000;
    localparam logic [7:0] E_REDIR = 8'b00000_110;
    localparam logic [7:0] E_MD    = 8'b11100_001;
    localparam logic [7:0] E_HZ    = 8'b11000_010;
    localparam logic [7:0] E_RST   = 8'b00000_111;

    typedef struct {
        logic [6:0] in;
        logic [7:0] e;
        logic [2:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst, hz, br, ms, md, req, ack, clr;

    logic a_pc_s, a_ifid_s, a_ifid_f, a_idex_s, a_idex_f, a_exmem_s, a_exmem_f, a_memwb_s;
    logic [2:0]  a_st;
    logic        a_mdto;
    logic [31:0] a_scnt, a_fcnt;

    logic b_pc_s, b_ifid_s, b_ifid_f, b_idex_s, b_idex_f, b_exmem_s, b_exmem_f, b_memwb_s;
    logic [2:0] b_st;
    logic       b_mdto;
    logic [3:0] b_scnt, b_fcnt;

    logic [7:0] a_e, b_e;
    assign a_e = {a_pc_s, a_ifid_s, a_idex_s, a_exmem_s, a_memwb_s, a_ifid_f, a_idex_f, a_exmem_f};
    assign b_e = {b_pc_s, b_ifid_s, b_idex_s, b_exmem_s, b_memwb_s, b_ifid_f, b_idex_f, b_exmem_f};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl u_dut_a (
        .clk(clk), .rst(rst), .hz(hz), .branch_taken(br), .muldiv_start(ms),
        .muldiv_done(md), .dmem_req(req), .dmem_ack(ack), .cnt_clr(clr),
        .pc_stall(a_pc_s), .ifid_stall(a_ifid_s), .ifid_flush(a_ifid_f),
        .idex_stall(a_idex_s), .idex_flush(a_idex_f), .exmem_stall(a_exmem_s),
        .exmem_flush(a_exmem_f), .memwb_stall(a_memwb_s), .ctrl_state(a_st),
        .md_timeout(a_mdto), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(2), .MD_TIMEOUT(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .hz(hz), .branch_taken(br), .muldiv_start(ms),
        .muldiv_done(md), .dmem_req(req), .dmem_ack(ack), .cnt_clr(clr),
        .pc_stall(b_pc_s), .ifid_stall(b_ifid_s), .ifid_flush(b_ifid_f),
        .idex_stall(b_idex_s), .idex_flush(b_idex_f), .exmem_stall(b_exmem_s),
        .exmem_flush(b_exmem_f), .memwb_stall(b_memwb_s), .ctrl_state(b_st),
        .md_timeout(b_mdto), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [6:0] in);
        {hz, br, ms, md, req, ack, clr} = in;
    endtask

    // Inputs change at posedge+1, outputs are checked at posedge+4.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input string name, input logic [6:0] in,
                          input logic [7:0] e, input logic [2:0] st);
        apply(in);
        #3;
        check({name, " b enables"}, 32'(b_e), 32'(e));
        check({name, " b state"}, 32'(b_st), 32'(st));
        tick();
    endtask

    vec_t vecs[21];

    initial begin
        // Cycle-by-cycle trace for the default instance, starting from RUN after reset.
        vecs[0]  = '{I_NONE,              E_NONE,  3'd0};
        vecs[1]  = '{I_HZ,                E_HZ,    3'd0};  // load-use bubble
        vecs[2]  = '{I_HZ | I_BR,         E_REDIR, 3'd0};  // redirect beats hazard
        vecs[3]  = '{I_REQ | I_BR,        E_MEM,   3'd0};  // mem stall beats redirect
        vecs[4]  = '{I_REQ | I_BR,        E_MEM,   3'd1};
        vecs[5]  = '{I_REQ | I_BR,        E_MEM,   3'd1};
        vecs[6]  = '{I_REQ | I_ACK | I_BR, E_REDIR, 3'd1}; // redirect in the ack cycle
        vecs[7]  = '{I_NONE,              E_NONE,  3'd0};
        vecs[8]  = '{I_ACK,               E_NONE,  3'd0};  // stray ack ignored
        vecs[9]  = '{I_MS | I_MD,         E_NONE,  3'd0};  // single-cycle mul/div
        vecs[10] = '{I_MS,                E_MD,    3'd0};
        vecs[11] = '{I_NONE,              E_MD,    3'd3};
        vecs[12] = '{I_HZ,                E_MD,    3'd3};
        vecs[13] = '{I_MD,                E_NONE,  3'd3};  // stall drops on done
        vecs[14] = '{I_NONE,              E_NONE,  3'd0};
        vecs[15] = '{I_MS | I_REQ,        E_MEM,   3'd0};  // mem stall beats mul/div
        vecs[16] = '{I_ACK,               E_NONE,  3'd1};
        vecs[17] = '{I_HZ | I_MS,         E_MD,    3'd0};  // mul/div beats hazard
        vecs[18] = '{I_REQ,               E_MD,    3'd3};  // dmem ignored in MD_WAIT
        vecs[19] = '{I_MD,                E_NONE,  3'd3};
        vecs[20] = '{I_NONE,              E_NONE,  3'd0};

        // Reset: front stages flushed, no stalls, counters cleared.
        rst = 1'b1;
        apply(I_NONE);
        tick();
        tick();
        check("reset a enables", 32'(a_e), 32'(E_RST));
        check("reset b enables", 32'(b_e), 32'(E_RST));
        check("reset a state", 32'(a_st), 32'd0);
        check("reset a stall_cnt", a_scnt, 32'd0);
        check("reset a flush_cnt", a_fcnt, 32'd0);
        check("reset b md_timeout", 32'(b_mdto), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i].in);
            #3;
            check($sformatf("vec%0d enables", i), 32'(a_e), 32'(vecs[i].e));
            check($sformatf("vec%0d state", i), 32'(a_st), 32'(vecs[i].st));
            tick();
        end
        check("table stall_cnt", a_scnt, 32'd10);
        check("table flush_cnt", a_fcnt, 32'd2);
        check("table md_timeout", 32'(a_mdto), 32'd0);

        // Fresh start for the second instance.
        rst = 1'b1;
        apply(I_NONE);
        tick();
        rst = 1'b0;

        // Two-cycle redirect: state RUN, FLUSH, RUN.
        step_b("flush c0", I_BR, E_REDIR, 3'd0);
        step_b("flush c1", I_NONE, E_REDIR, 3'd2);
        apply(I_NONE);
        #3;
        check("flush b flush_cnt", 32'(b_fcnt), 32'd1);
        tick();

        // A memory stall inside FLUSH freezes the flush countdown.
        step_b("freeze c0", I_BR, E_REDIR, 3'd0);
        step_b("freeze c1", I_REQ, E_MEM, 3'd2);
        step_b("freeze c2", I_REQ | I_ACK, E_REDIR, 3'd2);
        step_b("freeze c3", I_NONE, E_NONE, 3'd0);
        check("freeze b flush_cnt", 32'(b_fcnt), 32'd2);
        check("freeze b stall_cnt", 32'(b_scnt), 32'd1);

        // Mul/div timeout with MD_TIMEOUT=4: start cycle plus three waiting cycles.
        step_b("tmo c0", I_MS, E_MD, 3'd0);
        step_b("tmo c1", I_NONE, E_MD, 3'd3);
        step_b("tmo c2", I_NONE, E_MD, 3'd3);
        apply(I_NONE);
        #3;
        check("tmo c3 b enables", 32'(b_e), 32'(E_NONE));
        check("tmo c3 b state", 32'(b_st), 32'd3);
        check("tmo c3 b md_timeout", 32'(b_mdto), 32'd0);
        tick();
        #3;
        check("tmo c4 b state", 32'(b_st), 32'd0);
        check("tmo c4 b md_timeout", 32'(b_mdto), 32'd1);
        tick();

        // Mul/div done five cycles after start on the default instance.
        apply(I_MS);
        #3;
        check("md5 c0 a enables", 32'(a_e), 32'(E_MD));
        tick();
        for (int i = 1; i < 5; i++) begin
            apply(I_NONE);
            #3;
            check($sformatf("md5 c%0d a enables", i), 32'(a_e), 32'(E_MD));
            check($sformatf("md5 c%0d a state", i), 32'(a_st), 32'd3);
            tick();
        end
        apply(I_MD);
        #3;
        check("md5 c5 a enables", 32'(a_e), 32'(E_NONE));
        tick();
        apply(I_NONE);
        #3;
        check("md5 c6 a state", 32'(a_st), 32'd0);
        tick();

        // 20 stall cycles saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            apply(I_HZ);
            tick();
        end
        apply(I_NONE);
        #3;
        check("sat b stall_cnt", 32'(b_scnt), 32'd15);
        check("sat b md_timeout sticky", 32'(b_mdto), 32'd1);
        tick();

        // Clear wins over a same-cycle increment; md_timeout survives it.
        apply(I_HZ | I_CLR);
        #3;
        check("clr b enables", 32'(b_e), 32'(E_HZ));
        tick();
        apply(I_NONE);
        #3;
        check("clr b stall_cnt", 32'(b_scnt), 32'd0);
        check("clr b flush_cnt", 32'(b_fcnt), 32'd0);
        check("clr a stall_cnt", a_scnt, 32'd0);
        check("clr b md_timeout", 32'(b_mdto), 32'd1);
        tick();

        // Reset in the middle of MEM_WAIT returns to RUN with everything cleared.
        step_b("rstmw c0", I_REQ, E_MEM, 3'd0);
        apply(I_REQ);
        #3;
        check("rstmw c1 b state", 32'(b_st), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmw rst b enables", 32'(b_e), 32'(E_RST));
        tick();
        rst = 1'b0;
        apply(I_NONE);
        #3;
        check("rstmw b state", 32'(b_st), 32'd0);
        check("rstmw b stall_cnt", 32'(b_scnt), 32'd0);
        check("rstmw b md_timeout", 32'(b_mdto), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
